// File: rtl/serial_adder_fsm.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_fsm
// Description : Bit-serial unsigned adder, LSB-first, one full-adder cell and
//               a carry flop, wrapped in a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);

    localparam int               c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADD  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               w_load;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-2:0]   r_sum_sh;
    logic               r_c;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_s;
    logic               w_c_next;
    logic [WIDTH-1:0]   w_sum_word;

    assign w_s        = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c_next   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    // New bit enters at the top; on the final bit this is the finished word.
    assign w_sum_word = {w_s, r_sum_sh};

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_next = c_ADD;
                    w_load       = 1'b1;
                end
            end
            c_ADD: begin
                if (r_cnt == c_LAST) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                if (start) begin
                    w_state_next = c_ADD;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            Sum      <= '0;
            Carry    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum_sh <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            busy    <= (w_state_next == c_ADD);
            done    <= (w_state_next == c_DONE);
            if (w_load) begin
                r_a   <= input1;
                r_b   <= input2;
                r_c   <= 1'b0;
                r_cnt <= '0;
            end else if (r_state == c_ADD) begin
                r_a      <= {1'b0, r_a[WIDTH-1:1]};
                r_b      <= {1'b0, r_b[WIDTH-1:1]};
                r_sum_sh <= w_sum_word[WIDTH-1:1];
                r_c      <= w_c_next;
                r_cnt    <= r_cnt + c_CNT_W'(1);
                if (r_cnt == c_LAST) begin
                    Sum   <= w_sum_word;
                    Carry <= w_c_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/serial_adder_fsm.md
Name: serial_adder_fsm

Overview:
- Bit-serial ripple adder; the additive counterpart of the team's half-subtractor gate blocks.
- Adds two WIDTH-bit unsigned operands LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop.
- A start/busy/done handshake wraps the datapath. It is used where area matters more than latency, and serves as the building block for later serial ALU work.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2 to 32.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled on a rising clk edge.
- input1  input  WIDTH  operand A; sampled only in the cycle start is accepted.
- input2  input  WIDTH  operand B; sampled only in the cycle start is accepted.
- busy  output  1  high while the addition is in progress (ADD state).
- done  output  1  one-cycle pulse; Sum/Carry are valid from this cycle.
- Sum  output  WIDTH  registered result (input1 + input2) mod 2^WIDTH.
- Carry  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Reset, asynchronous, active-high:
  - state=IDLE; busy=0, done=0, Sum=0, Carry=0.
  - Internal shift registers, carry flop and bit counter cleared.
  - Reset asserted mid-ADD aborts the operation with no done pulse; Sum/Carry read 0 after reset.
- States: IDLE, ADD, DONE (one-hot or binary, implementer's choice). Outputs busy and done are registered, derived from state.
- IDLE:
  - start=1 at an edge loads the A and B shift registers from input1/input2, clears the carry flop and the counter, and moves to ADD.
  - start=0 stays in IDLE.
- ADD (busy=1), one bit per edge:
  - s = A[0] ^ B[0] ^ c.
  - c_next = (A[0]&B[0]) | (A[0]&c) | (B[0]&c).
  - A and B shift right by one.
  - s shifts into the MSB of the internal sum shift register.
  - counter increments.
- ADD completion:
  - On the edge processing bit WIDTH-1 (counter == WIDTH-1), the completed sum word and c_next are written to Sum/Carry, and the state moves to DONE.
- DONE (done=1, busy=0): lasts exactly one cycle.
  - start=1 at this edge is accepted as a new request (load, go to ADD); this gives back-to-back operation.
  - Otherwise go to IDLE.
- start while in ADD is ignored; operands are not re-sampled.
- input1/input2 changes outside the accept cycle have no effect.
- Latency:
  - start sampled at edge E0 gives busy=1 after E0.
  - Bits are processed at edges E1..E_WIDTH.
  - done=1 and Sum/Carry valid after edge E_WIDTH, i.e. WIDTH cycles after acceptance.
  - done deasserts after edge E_WIDTH+1.
  - Throughput is one result per WIDTH+1 cycles when start is held high.
- Sum/Carry hold their last completed value through IDLE and during a following ADD. They change only at completion or reset.
- Wrap-around: the result is modulo 2^WIDTH; overflow appears only on Carry.

Test Plan:
- WIDTH=8, reset pulse mid-idle -> busy=0, done=0, Sum=8'h00, Carry=0 immediately (asynchronously), before any clk edge.
- start one cycle with input1=8'h3C, input2=8'h05 -> busy for 8 cycles, done pulses exactly 8 cycles after acceptance, Sum=8'h41, Carry=0, held afterwards.
- input1=8'hFF, input2=8'h01 -> Sum=8'h00, Carry=1. Then 8'h00+8'h00 -> Sum=8'h00, Carry=0 (carry flop cleared on load).
- start held high continuously with operands 8'h80+8'h80 then 8'h0F+8'hF0 -> done pulses 9 cycles apart; results 8'h00/C=1 then 8'hFF/C=0.
- start pulsed again at cycle 3 of ADD with different operands -> ignored; the original result is delivered at the original done time.
- reset asserted at cycle 4 of ADD (Sum previously 8'h41) -> busy drops immediately, no done pulse, Sum=8'h00, Carry=0; a subsequent start completes normally.
